pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of pwm_in in 1/16-period steps.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to add a 3-sample majority filter on the synced input.
module pwm_capture #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int PWM_FREQ = 10_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [4:0] duty,
  output logic       duty_valid,
  output logic       locked,
  output logic       period_err,
  output logic       timeout
);
  localparam int PWM_STEPS   = 16;
  localparam int STEP_CYCLES = CLK_FREQ / (PWM_FREQ * PWM_STEPS);
  localparam int TO_CYCLES   = 32 * STEP_CYCLES;
  localparam int CNT_W       = $clog2(TO_CYCLES + 1);

  localparam logic [CNT_W-1:0] SC_C    = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(STEP_CYCLES / 2);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TO_CYCLES);
  localparam logic [CNT_W-1:0] TOM1_C  = CNT_W'(TO_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(PWM_STEPS);
  localparam logic [CNT_W-1:0] LO_C    = CNT_W'(PWM_STEPS - 1);
  localparam logic [CNT_W-1:0] HI_C    = CNT_W'(PWM_STEPS + 1);

  typedef enum logic {IDLE, MEASURE} state_t;

  // Round-half-up conversion of a cycle count into step units.
  function automatic logic [CNT_W-1:0] quantize(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] whole;
    logic [CNT_W-1:0] frac;
    whole = cnt / SC_C;
    frac  = cnt % SC_C;
    return (frac >= HALF_C) ? whole + ONE_C : whole;
  endfunction

  function automatic logic [4:0] sat_duty(input logic [CNT_W-1:0] steps);
    return (steps > FULL_C) ? 5'd16 : steps[4:0];
  endfunction

  logic sync1_q, sync2_q;
  logic lvl;
  logic lvl_q, rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic maj1_q, maj2_q, filt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maj1_q <= 1'b0;
      maj2_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      maj1_q <= sync2_q;
      maj2_q <= maj1_q;
      filt_q <= (sync2_q & maj1_q) | (sync2_q & maj2_q) | (maj1_q & maj2_q);
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  // lvl_q is the level aligned with rise_q; it feeds both the high counter and timeout duty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      lvl_q  <= lvl;
      rise_q <= lvl & ~lvl_q;
    end
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] p_steps, h_steps;
  logic [4:0]       duty_q, duty_d;
  logic             duty_valid_q, duty_valid_d;
  logic             locked_q, locked_d;
  logic             period_err_q, period_err_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      duty_q       <= 5'd0;
      duty_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      period_err_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      locked_q     <= locked_d;
      period_err_q <= period_err_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    period_cnt_d = (period_cnt_q == TO_C) ? TO_C : period_cnt_q + ONE_C;
    high_cnt_d   = (high_cnt_q == TO_C || !lvl_q) ? high_cnt_q : high_cnt_q + ONE_C;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    locked_d     = locked_q;
    period_err_d = 1'b0;
    timeout_d    = timeout_q;
    p_steps      = quantize(period_cnt_q);
    h_steps      = quantize(high_cnt_q);

    if (rise_q) begin
      // The rise cycle itself is the first cycle of the new period, and it is high.
      period_cnt_d = ONE_C;
      high_cnt_d   = ONE_C;
      timeout_d    = 1'b0;
      state_d      = MEASURE;
      if (state_q == MEASURE) begin
        if (p_steps >= LO_C && p_steps <= HI_C) begin
          duty_d       = sat_duty(h_steps);
          duty_valid_d = 1'b1;
          locked_d     = 1'b1;
        end else begin
          period_err_d = 1'b1;
          locked_d     = 1'b0;
        end
      end
    end else if (period_cnt_q == TOM1_C) begin
      // Fires once: the counter then saturates at TO_C and never matches again.
      timeout_d    = 1'b1;
      locked_d     = 1'b0;
      duty_d       = lvl_q ? 5'd16 : 5'd0;
      duty_valid_d = 1'b1;
      state_d      = IDLE;
    end
  end

  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
  assign locked     = locked_q;
  assign period_err = period_err_q;
  assign timeout    = timeout_q;

endmodule
